// File: rtl/alu_seq_if.sv
// Request/control bundle between an operation requester and the alu_seq sequencer.
// o_flags_snap exists only when ALU_SEQ_FLAG_SNAP_EN is defined.
interface alu_seq_if;
  logic       i_start;
  logic [2:0] i_op;
  logic [4:0] i_flags;
  logic [2:0] ctrl_alu_op;
  logic       ctrl_alu_en;
  logic       C9;
  logic       C10;
  logic       o_acc_wr_lo;
  logic       o_acc_wr_hi;
  logic       o_busy;
  logic       o_done;
  logic       o_overrun;
  logic [15:0] o_op_count;
  logic [2:0] dbg_state;
`ifdef ALU_SEQ_FLAG_SNAP_EN
  logic [4:0] o_flags_snap;
`endif

  // Handshake: i_start is a level request, sampled only while o_busy is low;
  // a request raised while o_busy is high is dropped and reported via o_overrun.
`ifdef ALU_SEQ_FLAG_SNAP_EN
  modport master (output i_start, i_op, i_flags,
                  input  ctrl_alu_op, ctrl_alu_en, C9, C10, o_acc_wr_lo, o_acc_wr_hi,
                         o_busy, o_done, o_overrun, o_op_count, dbg_state, o_flags_snap);
  modport slave  (input  i_start, i_op, i_flags,
                  output ctrl_alu_op, ctrl_alu_en, C9, C10, o_acc_wr_lo, o_acc_wr_hi,
                         o_busy, o_done, o_overrun, o_op_count, dbg_state, o_flags_snap);
`else
  modport master (output i_start, i_op, i_flags,
                  input  ctrl_alu_op, ctrl_alu_en, C9, C10, o_acc_wr_lo, o_acc_wr_hi,
                         o_busy, o_done, o_overrun, o_op_count, dbg_state);
  modport slave  (input  i_start, i_op, i_flags,
                  output ctrl_alu_op, ctrl_alu_en, C9, C10, o_acc_wr_lo, o_acc_wr_hi,
                         o_busy, o_done, o_overrun, o_op_count, dbg_state);
`endif
endinterface

// File: rtl/alu_seq.sv
// Moore sequencer driving one ALU operation: EX, low writeback, optional high writeback (MPY), DONE.
// Optional flag snapshot register enabled by ALU_SEQ_FLAG_SNAP_EN.
module alu_seq (
  input logic     i_clk,
  input logic     i_rst_n,
  alu_seq_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_EX    = 3'd1,
    S_WB_LO = 3'd2,
    S_WB_HI = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_MPY = 3'b010;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  alu_op_q;
  logic        overrun_q;
  logic [15:0] op_count_q;
  logic        accept;
  logic        alu_en;
  logic        gate_lo;
  logic        gate_hi;
  logic        busy;
  logic        done;

  assign accept = (state_q == S_IDLE) && bus.i_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.i_start) state_d = S_EX;
      S_EX:    state_d = S_WB_LO;
      S_WB_LO: state_d = (alu_op_q == OP_MPY) ? S_WB_HI : S_DONE;
      S_WB_HI: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    alu_en  = 1'b0;
    gate_lo = 1'b0;
    gate_hi = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE:  busy    = 1'b0;
      S_EX:    alu_en  = 1'b1;
      S_WB_LO: gate_lo = 1'b1;
      S_WB_HI: gate_hi = 1'b1;
      S_DONE:  done    = 1'b1;
      default: busy    = 1'b0;
    endcase
  end

  // Opcode stays latched after completion so the ALU keeps a stable op code while idle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      alu_op_q   <= 3'b000;
      overrun_q  <= 1'b0;
      op_count_q <= 16'h0000;
    end else begin
      if (accept) begin
        alu_op_q  <= bus.i_op;
        overrun_q <= 1'b0;
      end else if (bus.i_start && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      if ((state_q == S_DONE) && (op_count_q != 16'hFFFF))
        op_count_q <= op_count_q + 16'd1;
    end
  end

`ifdef ALU_SEQ_FLAG_SNAP_EN
  logic [4:0] flags_snap_q;

  // Flags are captured on the DONE exit edge, after the ALU ZF/NF update has settled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)               flags_snap_q <= 5'b00000;
    else if (state_q == S_DONE) flags_snap_q <= bus.i_flags;
  end

  assign bus.o_flags_snap = flags_snap_q;
`else
  logic unused_flags;
  assign unused_flags = ^bus.i_flags;
`endif

  assign bus.ctrl_alu_op = alu_op_q;
  assign bus.ctrl_alu_en = alu_en;
  assign bus.C9          = gate_lo;
  assign bus.C10         = gate_hi;
  assign bus.o_acc_wr_lo = gate_lo;
  assign bus.o_acc_wr_hi = gate_hi;
  assign bus.o_busy      = busy;
  assign bus.o_done      = done;
  assign bus.o_overrun   = overrun_q;
  assign bus.o_op_count  = op_count_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: per-cycle strobe patterns, overrun, reset mid-MPY, saturation,
// and the ALU_SEQ_FLAG_SNAP_EN snapshot when that macro is defined.
module tb_alu_seq;

  localparam logic [6:0] P_EX    = 7'b1000010;
  localparam logic [6:0] P_WB_LO = 7'b0101010;
  localparam logic [6:0] P_WB_HI = 7'b0010110;
  localparam logic [6:0] P_DONE  = 7'b0000011;
  localparam logic [6:0] P_IDLE  = 7'b0000000;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  logic [15:0] exp_count;
  logic [6:0]  exp_q[$];

  alu_seq_if bus ();

  alu_seq dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {bus.ctrl_alu_en, bus.C9, bus.C10, bus.o_acc_wr_lo, bus.o_acc_wr_hi,
            bus.o_busy, bus.o_done};
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {25'd0, strobes()}, {25'd0, P_IDLE});
    check({tag, "_alu_op"},  {29'd0, bus.ctrl_alu_op}, 32'd0);
    check({tag, "_overrun"}, {31'd0, bus.o_overrun}, 32'd0);
    check({tag, "_count"},   {16'd0, bus.o_op_count}, 32'd0);
    check({tag, "_state"},   {29'd0, bus.dbg_state}, 32'd0);
`ifdef ALU_SEQ_FLAG_SNAP_EN
    check({tag, "_snap"},    {27'd0, bus.o_flags_snap}, 32'd0);
`endif
  endtask

  // Driver: called at a negedge; start sampled on the next rising edge.
  task automatic run_op(input logic [2:0] op, input logic [4:0] fl, input bit poke_done);
    logic [6:0] exp;
    exp_q.push_back(P_EX);
    exp_q.push_back(P_WB_LO);
    if (op == 3'b010) exp_q.push_back(P_WB_HI);
    exp_q.push_back(P_DONE);
    exp_q.push_back(P_IDLE);
    bus.i_start = 1'b1;
    bus.i_op    = op;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      exp = exp_q.pop_front();
      check("strobes", {25'd0, strobes()}, {25'd0, exp});
      check("alu_op", {29'd0, bus.ctrl_alu_op}, {29'd0, op});
      if (exp == P_DONE) begin
        bus.i_flags = fl;
        if (poke_done) bus.i_start = 1'b1;
      end
    end
    if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    check("op_count", {16'd0, bus.o_op_count}, {16'd0, exp_count});
    check("overrun", {31'd0, bus.o_overrun}, {31'd0, poke_done});
`ifdef ALU_SEQ_FLAG_SNAP_EN
    check("flags_snap", {27'd0, bus.o_flags_snap}, {27'd0, fl});
`endif
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    exp_count = 16'd0;
    rst_n = 1'b0;
    bus.i_start = 1'b0;
    bus.i_op    = 3'b000;
    bus.i_flags = 5'b00000;

    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // first start honoured on first edge after reset release
    run_op(3'b000, 5'b00001, 1'b0);
    run_op(3'b010, 5'b00100, 1'b0);
    run_op(3'b001, 5'b01000, 1'b0);
    run_op(3'b111, 5'b00010, 1'b0);
    run_op(3'b110, 5'b00000, 1'b0);

    // overrun while busy: second request dropped
    bus.i_start = 1'b1;
    bus.i_op    = 3'b001;
    @(negedge clk);
    check("ovr_ex", {25'd0, strobes()}, {25'd0, P_EX});
    bus.i_op = 3'b011;
    @(negedge clk);
    bus.i_start = 1'b0;
    check("ovr_wb_lo", {25'd0, strobes()}, {25'd0, P_WB_LO});
    check("ovr_flag", {31'd0, bus.o_overrun}, 32'd1);
    check("ovr_op_hold", {29'd0, bus.ctrl_alu_op}, 32'd1);
    @(negedge clk);
    check("ovr_done", {25'd0, strobes()}, {25'd0, P_DONE});
    @(negedge clk);
    exp_count = exp_count + 16'd1;
    check("ovr_idle", {25'd0, strobes()}, {25'd0, P_IDLE});
    check("ovr_sticky", {31'd0, bus.o_overrun}, 32'd1);
    check("ovr_op_idle", {29'd0, bus.ctrl_alu_op}, 32'd1);
    check("ovr_count", {16'd0, bus.o_op_count}, {16'd0, exp_count});
    run_op(3'b011, 5'b00000, 1'b0);

    // start in DONE: overrun, not queued
    run_op(3'b100, 5'b00000, 1'b1);
    @(negedge clk);
    check("done_no_queue", {25'd0, strobes()}, {25'd0, P_IDLE});
    run_op(3'b101, 5'b00000, 1'b0);

    // reset during WB_LO of a multiply
    bus.i_start = 1'b1;
    bus.i_op    = 3'b010;
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    check("mid_wb_lo", {25'd0, strobes()}, {25'd0, P_WB_LO});
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_quiet", {25'd0, strobes()}, {25'd0, P_IDLE});
    end
    exp_count = 16'd0;

    // saturation
    force dut.op_count_q = 16'hFFFE;
    #1;
    release dut.op_count_q;
    exp_count = 16'hFFFE;
    run_op(3'b000, 5'b00000, 1'b0);
    run_op(3'b001, 5'b00000, 1'b0);
    run_op(3'b010, 5'b00000, 1'b0);

`ifdef ALU_SEQ_FLAG_SNAP_EN
    run_op(3'b000, 5'b10000, 1'b0);
    bus.i_flags = 5'b01111;
    repeat (2) @(negedge clk);
    check("snap_hold", {27'd0, bus.o_flags_snap}, 32'h10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
